// File: rtl/bram_port_arbiter.sv
// Shared BRAM port-B arbiter: per-channel req/gnt, optional burst lock, registered
// BRAM drive and tagged read return two cycles after the transfer edge.
module bram_port_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int MODE      = 0,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        lock,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic                     bram_we,
  output logic [DATA_W-1:0]        bram_wdata,
  input  logic [DATA_W-1:0]        bram_q
);

  // Handshake: a transfer on channel i happens at the rising edge where
  // req[i] & gnt[i]; the client holds addr/we/wdata stable until then.
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              owner_vld_q, owner_vld_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic              bram_we_q, bram_we_d;
  logic [DATA_W-1:0] bram_wdata_q, bram_wdata_d;
  logic [IDX_W-1:0]  tag_q, tag_d;
  logic              rd1_q, rd1_d;
  logic [NUM_CH-1:0] rvalid_q, rvalid_d;

  logic              hold;
  logic              sel_vld;
  logic [IDX_W-1:0]  sel;
  logic              xfer;
  int                idx;

  // Arbitration: a locked owner under its burst limit wins outright,
  // otherwise the MODE search picks the winner.
  always_comb begin
    hold    = 1'b0;
    sel_vld = 1'b0;
    sel     = '0;
    idx     = 0;
    if (owner_vld_q && req[owner_q] && lock[owner_q] &&
        (int'(burst_cnt_q) < MAX_BURST - 1)) begin
      hold = 1'b1;
    end
    if (hold) begin
      sel_vld = 1'b1;
      sel     = owner_q;
    end else if (MODE == 0) begin
      for (int off = NUM_CH - 1; off >= 0; off--) begin
        idx = (int'(ptr_q) + off) % NUM_CH;
        if (req[idx]) begin
          sel_vld = 1'b1;
          sel     = IDX_W'(idx);
        end
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req[i]) begin
          sel_vld = 1'b1;
          sel     = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    gnt  = '0;
    xfer = sel_vld & rst;
    if (xfer) begin
      gnt[sel] = 1'b1;
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    owner_vld_d  = 1'b0;
    burst_cnt_d  = '0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    bram_we_d    = 1'b0;
    tag_d        = tag_q;
    rd1_d        = 1'b0;
    if (xfer) begin
      ptr_d       = (int'(sel) == NUM_CH - 1) ? '0 : sel + 1'b1;
      owner_d     = sel;
      owner_vld_d = 1'b1;
      // Counter saturates so a channel repeatedly winning the normal search never wraps.
      if (owner_vld_q && (sel == owner_q) && lock[sel]) begin
        burst_cnt_d = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
      end
      bram_addr_d  = addr[int'(sel)*ADDR_W +: ADDR_W];
      bram_wdata_d = wdata[int'(sel)*DATA_W +: DATA_W];
      bram_we_d    = we[sel];
      tag_d        = sel;
      rd1_d        = ~we[sel];
    end
  end

  always_comb begin
    rvalid_d = '0;
    if (rd1_q) begin
      rvalid_d[tag_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q        <= '0;
      owner_q      <= '0;
      owner_vld_q  <= 1'b0;
      burst_cnt_q  <= '0;
      bram_addr_q  <= '0;
      bram_we_q    <= 1'b0;
      bram_wdata_q <= '0;
      tag_q        <= '0;
      rd1_q        <= 1'b0;
      rvalid_q     <= '0;
    end else begin
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      owner_vld_q  <= owner_vld_d;
      burst_cnt_q  <= burst_cnt_d;
      bram_addr_q  <= bram_addr_d;
      bram_we_q    <= bram_we_d;
      bram_wdata_q <= bram_wdata_d;
      tag_q        <= tag_d;
      rd1_q        <= rd1_d;
      rvalid_q     <= rvalid_d;
    end
  end

  // BRAM output is already registered inside the RAM; it is only steered here.
  assign rdata      = (|rvalid_q) ? bram_q : '0;
  assign rvalid     = rvalid_q;
  assign bram_addr  = bram_addr_q;
  assign bram_we    = bram_we_q;
  assign bram_wdata = bram_wdata_q;

endmodule
